// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU op codes, forwarding select and register constants for the MIPS core.
package mips_pkg;

    localparam logic [3:0] ALU_ADDU = 4'b0010;
    localparam logic [3:0] ALU_SUBU = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b1110;
    localparam logic [3:0] ALU_SRL  = 4'b0011;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// forward_unit: picks the youngest in-flight writer of one source register (never r0).
module forward_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] idx_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_result_i,
    output fwd_sel_e          sel_o,
    output logic [DATA_W-1:0] data_o
);

    logic exmem_hit, memwb_hit;

    assign exmem_hit = exmem_reg_write_i && exmem_rd_i != REG_AW'(REG_ZERO) && exmem_rd_i == idx_i;
    assign memwb_hit = memwb_reg_write_i && memwb_rd_i != REG_AW'(REG_ZERO) && memwb_rd_i == idx_i;
    assign sel_o     = exmem_hit ? FWD_EXMEM : memwb_hit ? FWD_MEMWB : FWD_NONE;
    assign data_o    = exmem_hit ? exmem_result_i : memwb_result_i;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with forwarding, operand select and load-use detection.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [4:0]        id_shamt_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [CTRL_W-1:0] id_alu_ctrl_i,
    input  logic              id_src_imm_i,
    input  logic              id_src_shamt_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              id_mem_write_i,
    input  logic              id_mem_to_reg_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_result_i,
    output logic              hazard_o,
    output logic [DATA_W-1:0] alu_in1_o,
    output logic [DATA_W-1:0] alu_in2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_valid_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              mem_to_reg_o
);

    logic              valid_q, valid_d, reg_write_q, reg_write_d, mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;
    logic              src_imm_q, src_imm_d, src_shamt_q, src_shamt_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [4:0]        shamt_q, shamt_d;
    logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic              bubble;
    fwd_sel_e          rs_sel, rt_sel;
    logic [DATA_W-1:0] rs_src, rt_src, fwd_rs, fwd_rt;

    assign hazard_o = valid_q && mem_read_q && rd_q != REG_AW'(REG_ZERO) && id_valid_i &&
                      (rd_q == id_rs_i || rd_q == id_rt_i);
    assign bubble   = flush_i || (!stall_i && hazard_o);

    always_comb begin
        valid_d      = bubble ? 1'b0 : stall_i ? valid_q      : id_valid_i;
        reg_write_d  = bubble ? 1'b0 : stall_i ? reg_write_q  : id_reg_write_i;
        mem_read_d   = bubble ? 1'b0 : stall_i ? mem_read_q   : id_mem_read_i;
        mem_write_d  = bubble ? 1'b0 : stall_i ? mem_write_q  : id_mem_write_i;
        mem_to_reg_d = bubble ? 1'b0 : stall_i ? mem_to_reg_q : id_mem_to_reg_i;
        src_imm_d    = bubble ? 1'b0 : stall_i ? src_imm_q    : id_src_imm_i;
        src_shamt_d  = bubble ? 1'b0 : stall_i ? src_shamt_q  : id_src_shamt_i;
        alu_ctrl_d   = bubble ? '0   : stall_i ? alu_ctrl_q   : id_alu_ctrl_i;
        rs_data_d    = bubble ? '0   : stall_i ? rs_data_q    : id_rs_data_i;
        rt_data_d    = bubble ? '0   : stall_i ? rt_data_q    : id_rt_data_i;
        imm_d        = bubble ? '0   : stall_i ? imm_q        : id_imm_i;
        shamt_d      = bubble ? '0   : stall_i ? shamt_q      : id_shamt_i;
        rs_d         = bubble ? '0   : stall_i ? rs_q         : id_rs_i;
        rt_d         = bubble ? '0   : stall_i ? rt_q         : id_rt_i;
        rd_d         = bubble ? '0   : stall_i ? rd_q         : id_rd_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            src_imm_q    <= 1'b0;
            src_shamt_q  <= 1'b0;
            alu_ctrl_q   <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            shamt_q      <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            src_imm_q    <= src_imm_d;
            src_shamt_q  <= src_shamt_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            shamt_q      <= shamt_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
        end
    end

    forward_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .idx_i(rs_q), .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i),
        .exmem_result_i(exmem_result_i), .memwb_reg_write_i(memwb_reg_write_i),
        .memwb_rd_i(memwb_rd_i), .memwb_result_i(memwb_result_i), .sel_o(rs_sel), .data_o(rs_src)
    );

    forward_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .idx_i(rt_q), .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i),
        .exmem_result_i(exmem_result_i), .memwb_reg_write_i(memwb_reg_write_i),
        .memwb_rd_i(memwb_rd_i), .memwb_result_i(memwb_result_i), .sel_o(rt_sel), .data_o(rt_src)
    );

    assign fwd_rs = (rs_sel != FWD_NONE) ? rs_src : rs_data_q;
    assign fwd_rt = (rt_sel != FWD_NONE) ? rt_src : rt_data_q;

    // Shifts put the shifted value (rt) on in1 because the ALU shifts in1 by in2.
    assign alu_in1_o    = src_shamt_q ? fwd_rt : fwd_rs;
    assign alu_in2_o    = src_shamt_q ? DATA_W'(shamt_q) : src_imm_q ? imm_q : fwd_rt;
    assign alu_ctrl_o   = alu_ctrl_q;
    assign store_data_o = fwd_rt;
    assign ex_rd_o      = rd_q;
    assign ex_valid_o   = valid_q;
    assign reg_write_o  = reg_write_q && valid_q;
    assign mem_read_o   = mem_read_q && valid_q;
    assign mem_write_o  = mem_write_q && valid_q;
    assign mem_to_reg_o = mem_to_reg_q && valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: random and directed stimulus checked against an instruction-level model of ID/EX.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        stall_i, flush_i, id_valid_i;
    logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
    logic [4:0]  id_shamt_i, id_rs_i, id_rt_i, id_rd_i;
    logic [3:0]  id_alu_ctrl_i;
    logic        id_src_imm_i, id_src_shamt_i, id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i;
    logic        exmem_reg_write_i, memwb_reg_write_i;
    logic [4:0]  exmem_rd_i, memwb_rd_i;
    logic [31:0] exmem_result_i, memwb_result_i;
    logic        hazard_o, ex_valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o;
    logic [31:0] alu_in1_o, alu_in2_o, store_data_o;
    logic [3:0]  alu_ctrl_o;
    logic [4:0]  ex_rd_o;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
        .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
        .id_shamt_i(id_shamt_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
        .id_alu_ctrl_i(id_alu_ctrl_i), .id_src_imm_i(id_src_imm_i), .id_src_shamt_i(id_src_shamt_i),
        .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
        .id_mem_to_reg_i(id_mem_to_reg_i), .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i),
        .exmem_result_i(exmem_result_i), .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i),
        .memwb_result_i(memwb_result_i), .hazard_o(hazard_o), .alu_in1_o(alu_in1_o), .alu_in2_o(alu_in2_o),
        .alu_ctrl_o(alu_ctrl_o), .store_data_o(store_data_o), .ex_rd_o(ex_rd_o), .ex_valid_o(ex_valid_o),
        .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_to_reg_o(mem_to_reg_o)
    );

    // The instruction currently sitting in EX, as the model sees it.
    typedef struct packed {
        logic        valid, rw, mr, mw, m2r, simm, ssh;
        logic [3:0]  ctrl;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  shamt, rs, rt, rd;
    } instr_t;

    instr_t m;
    int errors = 0, checks = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fwd(logic [4:0] idx, logic [31:0] v);
        if (idx == 5'd0) return v;
        if (exmem_reg_write_i && exmem_rd_i == idx) return exmem_result_i;
        if (memwb_reg_write_i && memwb_rd_i == idx) return memwb_result_i;
        return v;
    endfunction

    function automatic logic exp_hazard();
        return rst_n && m.valid && m.mr && m.rd != 5'd0 && id_valid_i && (m.rd == id_rs_i || m.rd == id_rt_i);
    endfunction

    function automatic instr_t from_id();
        instr_t t;
        t = '{valid: id_valid_i, rw: id_reg_write_i, mr: id_mem_read_i, mw: id_mem_write_i,
              m2r: id_mem_to_reg_i, simm: id_src_imm_i, ssh: id_src_shamt_i, ctrl: id_alu_ctrl_i,
              rsd: id_rs_data_i, rtd: id_rt_data_i, imm: id_imm_i, shamt: id_shamt_i,
              rs: id_rs_i, rt: id_rt_i, rd: id_rd_i};
        return t;
    endfunction

    task automatic check_all();
        logic [31:0] a, b;
        a = fwd(m.rs, m.rsd);
        b = fwd(m.rt, m.rtd);
        check("hazard", 32'(hazard_o), 32'(exp_hazard()));
        check("in1", alu_in1_o, m.ssh ? b : a);
        check("in2", alu_in2_o, m.ssh ? {27'd0, m.shamt} : m.simm ? m.imm : b);
        check("ctrl", 32'(alu_ctrl_o), 32'(m.ctrl));
        check("store", store_data_o, b);
        check("rd", 32'(ex_rd_o), 32'(m.rd));
        check("ctl_bits", {27'd0, ex_valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o},
              {27'd0, m.valid, m.valid & m.rw, m.valid & m.mr, m.valid & m.mw, m.valid & m.m2r});
    endtask

    task automatic tick();
        instr_t nx;
        if (!rst_n || flush_i) nx = '0;
        else if (stall_i) nx = m;
        else if (exp_hazard()) nx = '0;
        else nx = from_id();
        @(posedge clk);
        m = nx;
        #1;
    endtask

    task automatic idle();
        {stall_i, flush_i, id_valid_i, id_src_imm_i, id_src_shamt_i} = '0;
        {id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i} = '0;
        {id_rs_data_i, id_rt_data_i, id_imm_i, id_shamt_i, id_rs_i, id_rt_i, id_rd_i, id_alu_ctrl_i} = '0;
        {exmem_reg_write_i, exmem_rd_i, exmem_result_i, memwb_reg_write_i, memwb_rd_i, memwb_result_i} = '0;
    endtask

    task automatic rand_inputs();
        stall_i = ($urandom_range(0, 7) == 0);
        flush_i = ($urandom_range(0, 9) == 0);
        id_valid_i = ($urandom_range(0, 5) != 0);
        id_rs_data_i = $urandom; id_rt_data_i = $urandom; id_imm_i = $urandom;
        id_shamt_i = 5'($urandom); id_alu_ctrl_i = 4'($urandom);
        id_rs_i = 5'($urandom_range(0, 3)); id_rt_i = 5'($urandom_range(0, 3)); id_rd_i = 5'($urandom_range(0, 3));
        id_src_imm_i = 1'($urandom); id_src_shamt_i = ($urandom_range(0, 3) == 0);
        id_reg_write_i = 1'($urandom); id_mem_read_i = 1'($urandom);
        id_mem_write_i = 1'($urandom); id_mem_to_reg_i = 1'($urandom);
        exmem_reg_write_i = 1'($urandom); exmem_rd_i = 5'($urandom_range(0, 3)); exmem_result_i = $urandom;
        memwb_reg_write_i = 1'($urandom); memwb_rd_i = 5'($urandom_range(0, 3)); memwb_result_i = $urandom;
    endtask

    initial begin
        idle();
        m = '0;
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            #1;
            check_all();
            tick();
        end

        // Forwarding priority on rs.
        idle(); id_valid_i = 1; id_rs_i = 5'd8; id_rs_data_i = 32'h1; tick();
        idle(); exmem_reg_write_i = 1; exmem_rd_i = 5'd8; exmem_result_i = 32'h55;
        memwb_reg_write_i = 1; memwb_rd_i = 5'd8; memwb_result_i = 32'h77; #1;
        check("fwd_exmem", alu_in1_o, 32'h55);
        exmem_reg_write_i = 0; #1;
        check("fwd_memwb", alu_in1_o, 32'h77);
        check_all();
        idle(); id_valid_i = 1; id_rs_i = 5'd0; id_rs_data_i = 32'h1; tick();
        exmem_reg_write_i = 1; memwb_reg_write_i = 1; exmem_result_i = 32'h55; memwb_result_i = 32'h77; #1;
        check("fwd_r0", alu_in1_o, 32'h1);

        // Load-use hazard, then the same with a load to r0.
        idle(); id_valid_i = 1; id_mem_read_i = 1; id_rd_i = 5'd9; tick();
        idle(); id_valid_i = 1; id_rs_i = 5'd9; #1;
        check("hz_on", 32'(hazard_o), 32'd1);
        tick();
        check("hz_bubble", {30'd0, ex_valid_o, mem_read_o}, 32'd0);
        idle(); id_valid_i = 1; id_mem_read_i = 1; id_rd_i = 5'd0; tick();
        idle(); id_valid_i = 1; id_rs_i = 5'd0; #1;
        check("hz_r0", 32'(hazard_o), 32'd0);

        // Shift operands.
        idle(); id_valid_i = 1; id_rt_i = 5'd5; id_rt_data_i = 32'h1; id_shamt_i = 5'd4;
        id_alu_ctrl_i = ALU_SLL; id_src_shamt_i = 1; id_reg_write_i = 1; tick();
        idle(); #1;
        check("sll_in1", alu_in1_o, 32'h1);
        check("sll_in2", alu_in2_o, 32'h4);
        check("sll_ctrl", 32'(alu_ctrl_o), 32'(ALU_SLL));
        memwb_reg_write_i = 1; memwb_rd_i = 5'd5; memwb_result_i = 32'h3; #1;
        check("sll_fwd", alu_in1_o, 32'h3);

        // Immediate operand.
        idle(); id_valid_i = 1; id_rs_i = 5'd2; id_rs_data_i = 32'h10; id_rt_i = 5'd3; id_rt_data_i = 32'hABCD;
        id_imm_i = 32'hFFFF_FFFF; id_src_imm_i = 1; id_reg_write_i = 1; id_alu_ctrl_i = ALU_ADDU; tick();
        idle(); #1;
        check("imm_in1", alu_in1_o, 32'h10);
        check("imm_in2", alu_in2_o, 32'hFFFF_FFFF);
        check("imm_rw", 32'(reg_write_o), 32'd1);
        check("imm_store", store_data_o, 32'hABCD);

        // Stall holds for three cycles, then stall plus flush loads a bubble.
        for (int i = 0; i < 3; i++) begin
            rand_inputs(); stall_i = 1; flush_i = 0; exmem_reg_write_i = 0; memwb_reg_write_i = 0;
            tick();
            check("stall_in2", alu_in2_o, 32'hFFFF_FFFF);
            check("stall_rw", 32'(reg_write_o), 32'd1);
        end
        stall_i = 1; flush_i = 1; tick();
        idle(); #1;
        check("flush_valid", 32'(ex_valid_o), 32'd0);
        check("flush_in2", alu_in2_o, 32'd0);
        check_all();

        // Asynchronous reset between edges.
        idle(); id_valid_i = 1; id_rs_data_i = 32'h5; id_rt_data_i = 32'h6; id_rs_i = 5'd1; id_rt_i = 5'd2;
        id_rd_i = 5'd3; id_reg_write_i = 1; id_mem_read_i = 1; id_alu_ctrl_i = ALU_ADDU; tick();
        id_rs_i = 5'd3; #2;
        rst_n = 1'b0; m = '0; #1;
        check("rst_valid", 32'(ex_valid_o), 32'd0);
        check("rst_hz", 32'(hazard_o), 32'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(); id_valid_i = 1; id_rs_data_i = 32'h5; id_rt_data_i = 32'h6; id_rs_i = 5'd1; id_rt_i = 5'd2;
        id_rd_i = 5'd3; id_reg_write_i = 1; id_alu_ctrl_i = ALU_ADDU; #1;
        check("post_rst_pending", 32'(ex_valid_o), 32'd0);
        tick();
        check("post_rst_in1", alu_in1_o, 32'h5);
        check("post_rst_in2", alu_in2_o, 32'h6);
        check_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-stage operand preparation for the 5-stage MIPS core.
- Captures decoded operands and control from ID and resolves EX/MEM and MEM/WB forwarding.
- Selects immediate/shamt sources and drives the ALU's in1, in2 and ALUControl directly.
- Detects load-use hazards and inserts a bubble; stall and flush come from the pipeline controller.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-index width
CTRL_W, 4, ALUControl width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hold ID/EX contents
flush_i  in  1  replace next ID/EX contents with a bubble
id_valid_i  in  1  ID holds a real instruction
id_rs_data_i / id_rt_data_i  in  DATA_W  register-file read data
id_imm_i  in  DATA_W  already-extended immediate
id_shamt_i  in  5  shift amount
id_rs_i / id_rt_i / id_rd_i  in  REG_AW  source and destination indices (rd already muxed rt/rd/31)
id_alu_ctrl_i  in  CTRL_W  ALU operation code
id_src_imm_i / id_src_shamt_i  in  1  operand-source selects
id_reg_write_i / id_mem_read_i / id_mem_write_i / id_mem_to_reg_i  in  1  downstream control
exmem_reg_write_i  in  1; exmem_rd_i  in  REG_AW; exmem_result_i  in  DATA_W  EX/MEM forward source
memwb_reg_write_i  in  1; memwb_rd_i  in  REG_AW; memwb_result_i  in  DATA_W  MEM/WB forward source
hazard_o  out  1  load-use stall request to PC and IF/ID
alu_in1_o / alu_in2_o  out  DATA_W  ALU operands
alu_ctrl_o  out  CTRL_W  ALU operation
store_data_o  out  DATA_W  forwarded rt value for sw
ex_rd_o  out  REG_AW  destination index
ex_valid_o / reg_write_o / mem_read_o / mem_write_o / mem_to_reg_o  out  1  control to EX/MEM

Behaviour:
- Reset: rst_n low clears every register asynchronously.
  - All 1-bit outputs go to 0; alu_ctrl_o, ex_rd_o and all data outputs go to 0.
  - hazard_o is 0 while reset is held.
- Latency: one cycle. Values presented in cycle N appear on outputs in cycle N+1.
- Update priority at each clk edge: flush_i > stall_i > hazard_o > normal load.
  - flush_i: load a bubble. valid, reg_write, mem_read, mem_write, mem_to_reg and alu_ctrl become 0; data fields become 0.
  - stall_i (no flush): hold all registers.
  - hazard_o (no flush/stall): load a bubble. Upstream holds IF/ID using hazard_o.
  - Otherwise: capture all id_* inputs.
- hazard_o is combinational and asserts when all of these hold:
  - ex_valid_o and mem_read_o are 1;
  - ex_rd_o != 0;
  - id_valid_i is 1;
  - ex_rd_o equals id_rs_i or id_rt_i. The rt compare is always made (conservative).
- Forwarding is combinational on the registered rs/rt data, evaluated per operand:
  - EX/MEM wins if exmem_reg_write_i = 1, exmem_rd_i != 0 and exmem_rd_i matches the registered index.
  - Otherwise MEM/WB under the same conditions.
  - Otherwise the registered value. Register 0 is never forwarded.
- Operand select:
  - id_src_shamt set: in1 = fwd_rt; in2 = zero-extended shamt. This covers sll/srl/sra, since the ALU shifts in1 by in2.
  - id_src_imm set: in1 = fwd_rs; in2 = imm.
  - Neither set: in1 = fwd_rs; in2 = fwd_rt.
  - Both set: shamt wins.
- store_data_o = fwd_rt, always.
- Control outputs reg_write_o, mem_read_o, mem_write_o and mem_to_reg_o are ANDed with ex_valid_o.
- Simultaneous flush and hazard: the flush bubble is loaded and hazard_o still asserts for that cycle. The controller resolves this.

Decomposition:
- Shared package mips_pkg holds:
  - ALU op constants: ADDU 0010, SUBU 0110, AND 0000, OR 0001, SLT 0111, XOR 1001, SLL 1010, SRA 1011, NOR 1100, SLTU 1110, SRL 0011;
  - forward-select enum FWD_NONE/FWD_EXMEM/FWD_MEMWB;
  - REG_ZERO.
- One combinational sub-module, forward_unit, is instantiated twice (rs, rt). It returns the select and the data.

Test Plan:
- Reset mid-operation: load add, deassert rst_n between edges -> all outputs 0 immediately and hazard_o 0; after release with valid ID, outputs appear one cycle later.
- Forward priority: registered rs = 8 with data 1; exmem writes r8 = 0x55, memwb writes r8 = 0x77 -> alu_in1_o = 0x55. Drop exmem_reg_write -> 0x77. Set rs = 0 with all matches -> registered value.
- Load-use: EX holds lw to r9; ID uses rs = 9 -> hazard_o = 1, next cycle ex_valid_o = 0, mem_read_o = 0. Same case with ex_rd = 0 -> hazard_o = 0.
- Shift operand: sll, rt data 0x1, shamt 4, ctrl 1010 -> in1 = 0x1, in2 = 0x4, alu_ctrl_o = 1010. Same with memwb forwarding rt = 0x3 -> in1 = 0x3.
- Stall vs flush: hold stall_i 3 cycles -> outputs unchanged. Assert stall and flush together -> bubble loaded.
- Immediate: addiu, rs data 0x10, imm 0xFFFFFFFF -> in2 = 0xFFFFFFFF, reg_write_o = 1, store_data_o = fwd_rt.
